retire_trace_ctrl: RTL

//  Captures the CPU retire record (inst_retire) into a trace buffer and sends it to a host-side sink over valid/ready.

---
 rtl/retire_trace_ctrl_pkg.sv | 35 +++
 rtl/retire_trace_ctrl_fifo.sv | 65 ++++++
 rtl/retire_trace_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/retire_trace_ctrl_pkg.sv
// Shared definitions for the retire trace controller.
//   - Field offsets of the 70-bit CPU retire record.
//   - Packed trace record (pc, waddr, wdata) as stored in the buffer.
//   - Controller FSM encoding.
package retire_trace_ctrl_pkg;

  localparam int unsigned PcLsb    = 0;
  localparam int unsigned WdataLsb = 32;
  localparam int unsigned WaddrLsb = 64;
  localparam int unsigned WenBit   = 69;
  localparam int unsigned RetireW  = 70;
  localparam int unsigned RecW     = 69;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } trace_rec_t;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDrain = 2'd1,
    StDone  = 2'd2
  } trace_state_e;

  // Extracts the buffered fields from a raw retire record (the wen bit is not stored).
  function automatic trace_rec_t unpack_retire(input logic [RetireW-1:0] r);
    trace_rec_t rec;
    rec.pc    = r[PcLsb    +: 32];
    rec.wdata = r[WdataLsb +: 32];
    rec.waddr = r[WaddrLsb +: 5];
    return rec;
  endfunction

endpackage

// File: rtl/retire_trace_ctrl_fifo.sv
// Registered synchronous FIFO, no write-to-read bypass.
//   clk_i/rst_i : clock, asynchronous active-high reset
//   push_i      : write request; accepted when not full or when a pop happens in the same cycle
//   pop_i       : read request; ignored when empty
//   din_i/dout_o: write data / head entry
//   full_o/empty_o/level_o : occupancy status, level is 0..Depth
module retire_trace_ctrl_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 69
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [Width-1:0]         din_i,
  output logic [Width-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW-1:0] PtrOne  = 1;
  localparam logic [PtrW:0]   LvlOne  = 1;
  localparam logic [PtrW:0]   LvlFull = (PtrW+1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    level_q;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LvlFull);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign dout_o  = mem_q[rptr_q];

  assign do_pop  = pop_i && !empty_o;
  // A pop frees the slot the push needs, so full+pop still accepts the push.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= din_i;
        wptr_q        <= wptr_q + PtrOne;
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PtrOne;
      end
      if (do_push && !do_pop) begin
        level_q <= level_q + LvlOne;
      end else if (do_pop && !do_push) begin
        level_q <= level_q - LvlOne;
      end
    end
  end

endmodule

// File: rtl/retire_trace_ctrl.sv
// Retire trace controller: captures retired register writes into a buffer and streams them
// to a host sink over valid/ready. An end-of-test store moves it to drain, and once the
// buffer is empty trace_done is raised until reset. Records arriving while the buffer is
// full are dropped and counted; the CPU is never stalled.
//   sys_clk/sys_reset        : clock, asynchronous active-high reset
//   trace_en, inst_retire    : capture enable, retire record {wen, waddr, wdata, pc}
//   mem_wen/addr/wdata       : CPU store bus, watched for the end-of-test store
//   trace_valid/ready + data : output record stream
//   trace_done, trace_ovf, ovf_cnt, fifo_level : status
module retire_trace_ctrl
  import retire_trace_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [31:0] END_ADDR   = 32'h0C,
  parameter logic [31:0] END_DATA   = 32'h0
) (
  input  logic                          sys_clk,
  input  logic                          sys_reset,
  input  logic                          trace_en,
  input  logic [RetireW-1:0]            inst_retire,
  input  logic                          mem_wen,
  input  logic [31:0]                   mem_addr,
  input  logic [31:0]                   mem_wdata,
  output logic                          trace_valid,
  input  logic                          trace_ready,
  output logic [31:0]                   trace_pc,
  output logic [4:0]                    trace_waddr,
  output logic [31:0]                   trace_wdata,
  output logic                          trace_done,
  output logic                          trace_ovf,
  output logic [15:0]                   ovf_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  trace_state_e state_q;
  logic         done_q, ovf_q;
  logic [15:0]  ovf_cnt_q;

  trace_rec_t   rec_in, rec_out;
  logic         push_req, end_hit, pop, drop;
  logic         fifo_full, fifo_empty;

  assign rec_in   = unpack_retire(inst_retire);
  assign push_req = (state_q == StRun) && trace_en && inst_retire[WenBit] && (rec_in.waddr != '0);
  assign end_hit  = mem_wen && (mem_addr == END_ADDR) && (mem_wdata == END_DATA);

  // Valid is a function of state and occupancy only, never of trace_ready.
  assign trace_valid = (state_q != StDone) && !fifo_empty;
  assign pop         = trace_valid && trace_ready;
  assign drop        = push_req && fifo_full && !pop;

  retire_trace_ctrl_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (RecW)
  ) u_fifo (
    .clk_i   (sys_clk),
    .rst_i   (sys_reset),
    .push_i  (push_req),
    .pop_i   (pop),
    .din_i   (rec_in),
    .dout_o  (rec_out),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q   <= StRun;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      ovf_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (end_hit) state_q <= StDrain;
        end
        StDrain: begin
          // Nothing is pushed in drain, so an empty buffer means nothing is in flight.
          if (fifo_empty) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: ;
        default: state_q <= StRun;
      endcase
      if (drop) begin
        ovf_q <= 1'b1;
        if (ovf_cnt_q != 16'hFFFF) ovf_cnt_q <= ovf_cnt_q + 16'd1;
      end
    end
  end

  assign trace_pc    = rec_out.pc;
  assign trace_waddr = rec_out.waddr;
  assign trace_wdata = rec_out.wdata;
  assign trace_done  = done_q;
  assign trace_ovf   = ovf_q;
  assign ovf_cnt     = ovf_cnt_q;

endmodule
